pe_result_collector: RTL and testbench



---
 rtl/pe_result_collector.sv | 175 +++++++++++++++++
 tb/tb_pe_result_collector.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// pe_result_collector: captures the 16 per-column PE cube results, widens
// strategy-1 lanes to 32 bits, sums i_acc_len result vectors per group and
// queues each group as one 512-bit beat in a first-word-fall-through FIFO
// towards the output SRAM/DMA writer.
// Optional macro RESULT_SATURATE_EN: lane adds saturate to the signed 32-bit
// range instead of wrapping (default build wraps).
module pe_result_collector #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [7:0]    i_acc_len,
    input  logic [15:0]   i_num_beats,
    input  logic          i_strategy_2_en,
    input  logic          i_result_valid,
    input  logic [335:0]  i_result_s1,
    input  logic [511:0]  i_result_s2,
    output logic          o_busy,
    output logic [511:0]  o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [CW-1:0] o_count,
    output logic          o_overflow,
    output logic          o_done
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = 16;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

    state_t         state_q;
    logic [7:0]     acc_len_q;
    logic [7:0]     grp_cnt_q;
    logic [7:0]     grp_cnt_d;
    logic [15:0]    num_beats_q;
    logic [15:0]    beat_cnt_q;
    logic [15:0]    beat_cnt_d;
    logic           overflow_q;
    logic           done_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [511:0]   mem_q [DEPTH];
    logic [511:0]   beat_d;

    logic busy;
    logic accept;
    logic grp_last;
    logic push;
    logic pop;

    // Busy depends only on registered state so it never loops back through i_ready
    assign busy      = (state_q != S_ACC) | (count_q == CW'(DEPTH));
    assign accept    = i_result_valid & ~busy;
    assign grp_last  = (grp_cnt_q + 8'd1) == acc_len_q;
    assign push      = accept & grp_last;
    assign pop       = (count_q != '0) & i_ready;
    assign grp_cnt_d = grp_last ? 8'd0 : grp_cnt_q + 8'd1;
    assign beat_cnt_d = push ? beat_cnt_q + 16'd1 : beat_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [31:0] x;
            logic [31:0] add_res;
            logic [31:0] lane_sum;
            logic [31:0] acc_q;

            assign x = i_strategy_2_en ? i_result_s2[32*gi +: 32]
                                       : {{11{i_result_s1[21*gi+20]}}, i_result_s1[21*gi +: 21]};
`ifdef RESULT_SATURATE_EN
            logic [32:0] wide;
            assign wide    = {acc_q[31], acc_q} + {x[31], x};
            assign add_res = (wide[32] != wide[31]) ? (wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                                    : wide[31:0];
`else
            assign add_res = acc_q + x;
`endif
            // First vector of a group overwrites the lane, later ones add
            assign lane_sum = (grp_cnt_q == 8'd0) ? x : add_res;
            assign beat_d[32*gi +: 32] = lane_sum;

            // Lane accumulator advances on every accepted result
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    acc_q <= '0;
                end else if (accept) begin
                    acc_q <= lane_sum;
                end
            end
        end
    endgenerate

    // Job control: latch job parameters, count groups and beats, drain, pulse done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            acc_len_q   <= '0;
            num_beats_q <= '0;
            grp_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        acc_len_q   <= (i_acc_len == 8'd0) ? 8'd1 : i_acc_len;
                        num_beats_q <= i_num_beats;
                        grp_cnt_q   <= '0;
                        beat_cnt_q  <= '0;
                        state_q     <= (i_num_beats == 16'd0) ? S_DRAIN : S_ACC;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        grp_cnt_q  <= grp_cnt_d;
                        beat_cnt_q <= beat_cnt_d;
                    end
                    if (push && (beat_cnt_d == num_beats_q)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (count_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Sticky drop flag, cleared only by an accepted start
            if ((state_q == S_IDLE) && i_start) begin
                overflow_q <= 1'b0;
            end else if (i_result_valid && busy) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Beat storage; contents need no reset because o_data is gated when empty
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= beat_d;
        end
    end

    assign o_busy     = busy;
    assign o_valid    = (count_q != '0);
    assign o_data     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector: directed scenarios plus randomized jobs, checked
// against a queue-based behavioural model of the collector.
module tb_pe_result_collector;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [7:0]    i_acc_len = '0;
    logic [15:0]   i_num_beats = '0;
    logic          i_strategy_2_en = 1'b0;
    logic          i_result_valid = 1'b0;
    logic [335:0]  i_result_s1 = '0;
    logic [511:0]  i_result_s2 = '0;
    logic          o_busy;
    logic [511:0]  o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_done;

    pe_result_collector #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_acc_len(i_acc_len), .i_num_beats(i_num_beats),
        .i_strategy_2_en(i_strategy_2_en), .i_result_valid(i_result_valid),
        .i_result_s1(i_result_s1), .i_result_s2(i_result_s2),
        .o_busy(o_busy), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_count(o_count), .o_overflow(o_overflow), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_vec;
    int n_err;

    // Behavioural model: job phase (0 idle, 1 collecting, 2 draining)
    int           m_phase;
    int           m_len;
    int           m_left;
    int           m_grp;
    logic [31:0]  m_acc [16];
    logic [511:0] m_fifo [$];
    bit           m_ovf;
    bit           m_done;

    function automatic logic [31:0] lane_add(logic [31:0] a, logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef RESULT_SATURATE_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] lane_x(int k);
        logic signed [20:0] s1v;
        int v;
        if (i_strategy_2_en) return i_result_s2[32*k +: 32];
        s1v = i_result_s1[21*k +: 21];
        v = s1v;
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_len = 1; m_left = 0; m_grp = 0;
        m_ovf = 0; m_done = 0;
        m_fifo.delete();
        for (int k = 0; k < 16; k++) m_acc[k] = '0;
    endtask

    // Drive one cycle of control inputs, advance the model, land on next negedge
    task automatic step(input bit start, input bit valid, input bit ready);
        bit busy, accept, pop, start_ok;
        int pre_size;
        logic [511:0] beat;
        logic [31:0] x;
        i_start = start; i_result_valid = valid; i_ready = ready;
        pre_size = m_fifo.size();
        busy     = (m_phase != 1) || (pre_size == DEPTH);
        accept   = valid && !busy;
        pop      = (pre_size != 0) && ready;
        start_ok = (m_phase == 0) && start;
        m_done   = 0;
        beat     = '0;
        if (pop) void'(m_fifo.pop_front());
        if (start_ok) begin
            m_len   = (i_acc_len == 8'd0) ? 1 : int'(i_acc_len);
            m_left  = int'(i_num_beats);
            m_grp   = 0;
            m_phase = (m_left == 0) ? 2 : 1;
        end else if (m_phase == 1 && accept) begin
            for (int k = 0; k < 16; k++) begin
                x = lane_x(k);
                m_acc[k] = (m_grp == 0) ? x : lane_add(m_acc[k], x);
                beat[32*k +: 32] = m_acc[k];
            end
            m_grp++;
            if (m_grp == m_len) begin
                m_grp = 0;
                m_fifo.push_back(beat);
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
        end else if (m_phase == 2 && pre_size == 0) begin
            m_done  = 1;
            m_phase = 0;
        end
        if (start_ok) m_ovf = 0;
        else if (valid && busy) m_ovf = 1;
        @(negedge i_clk);
    endtask

    task automatic rand_data();
        for (int k = 0; k < 16; k++) begin
            i_result_s1[21*k +: 21] = 21'($urandom);
            case ($urandom_range(0, 3))
                0:       i_result_s2[32*k +: 32] = $urandom;
                1:       i_result_s2[32*k +: 32] = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
                2:       i_result_s2[32*k +: 32] = 32'h8000_0000 + 32'($urandom_range(0, 15));
                default: i_result_s2[32*k +: 32] = 32'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (o_count !== '0)   begin n_err++; $display("FAIL reset_count: got %0d, required 0", o_count); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
        n_vec++; if (o_data !== '0)    begin n_err++; $display("FAIL reset_data: got %h, required 0", o_data); end
        n_vec++; if (o_overflow !== 1'b0 || o_done !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: overflow=%b done=%b, required 0 0", o_overflow, o_done);
        end
        n_vec++; if (o_busy !== 1'b1)  begin n_err++; $display("FAIL reset_busy: got %b, required 1 (idle)", o_busy); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_sign_ext();
        logic [511:0] exp_beat;
        exp_beat = {16{32'hFFFF_FFFF}};
        i_acc_len = 8'd1; i_num_beats = 16'd1; i_strategy_2_en = 1'b0;
        for (int k = 0; k < 16; k++) i_result_s1[21*k +: 21] = 21'h1F_FFFF;
        step(1, 0, 0);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL sext_busy: got %b, required 0", o_busy); end
        step(0, 1, 0);
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL sext_valid: got %b, required 1", o_valid); end
        n_vec++; if (o_data !== exp_beat) begin n_err++; $display("FAIL sext_data: got %h, required %h", o_data, exp_beat); end
        step(0, 0, 1);
        n_vec++; if (o_valid !== 1'b0 || o_done !== 1'b0) begin
            n_err++; $display("FAIL sext_pop: valid=%b done=%b, required 0 0", o_valid, o_done);
        end
        step(0, 0, 0);
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL sext_done: got %b, required 1", o_done); end
        step(0, 0, 0);
        n_vec++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            n_err++; $display("FAIL sext_idle: done=%b busy=%b, required 0 1", o_done, o_busy);
        end
        $display("test_sign_ext done");
    endtask

    task automatic test_accumulate();
        logic [511:0] exp_beat;
        bit got;
        i_acc_len = 8'd3; i_num_beats = 16'd2; i_strategy_2_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_result_s2[32*k +: 32] = 32'(k + 1);
            exp_beat[32*k +: 32]    = 32'(3 * (k + 1));
        end
        step(1, 0, 1);
        for (int v = 0; v < 6; v++) begin
            step(0, 1, 1);
            n_vec++; if (o_count !== CW'(0) && o_count !== CW'(1)) begin
                n_err++; $display("FAIL accum_count: vector %0d count=%0d, required <=1", v, o_count);
            end
            if (v == 2 || v == 5) begin
                n_vec++; if (o_valid !== 1'b1 || o_data !== exp_beat) begin
                    n_err++; $display("FAIL accum_beat: valid=%b data=%h, required 1 %h", o_valid, o_data, exp_beat);
                end
            end
        end
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            step(0, 0, 1);
            if (o_done === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL accum_done: o_done=0 for 8 cycles, required 1"); end
        $display("test_accumulate done");
    endtask

    task automatic test_back_pressure();
        logic [511:0] sent [$];
        bit got;
        i_acc_len = 8'd1; i_num_beats = 16'd6; i_strategy_2_en = 1'b1;
        step(1, 0, 0);
        for (int v = 0; v < 4; v++) begin
            rand_data(); sent.push_back(i_result_s2);
            step(0, 1, 0);
        end
        n_vec++; if (o_count !== CW'(4)) begin n_err++; $display("FAIL bp_count: got %0d, required 4", o_count); end
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b, required 1", o_busy); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL bp_ovf_early: got %b, required 0", o_overflow); end
        rand_data();
        step(0, 1, 0);
        n_vec++; if (o_overflow !== 1'b1 || o_count !== CW'(4)) begin
            n_err++; $display("FAIL bp_ovf: overflow=%b count=%0d, required 1 4", o_overflow, o_count);
        end
        for (int v = 0; v < 4; v++) begin
            n_vec++; if (o_data !== sent[v]) begin n_err++; $display("FAIL bp_order: beat %0d got %h, required %h", v, o_data, sent[v]); end
            step(0, 0, 1);
        end
        n_vec++; if (o_count !== '0 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL bp_drained: count=%0d busy=%b, required 0 0", o_count, o_busy);
        end
        for (int v = 4; v < 6; v++) begin
            rand_data(); sent.push_back(i_result_s2);
            step(0, 1, 1);
            n_vec++; if (o_valid !== 1'b1 || o_data !== sent[v]) begin
                n_err++; $display("FAIL bp_tail: beat %0d got %h, required %h", v, o_data, sent[v]);
            end
        end
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            step(0, 0, 1);
            if (o_done === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL bp_done: o_done=0 for 8 cycles, required 1"); end
        n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL bp_ovf_sticky: got %b, required 1", o_overflow); end
        $display("test_back_pressure done");
    endtask

    task automatic test_wrap_sat();
        logic [511:0] exp_beat;
        bit got;
`ifdef RESULT_SATURATE_EN
        exp_beat = {16{32'h7FFF_FFFF}};
`else
        exp_beat = {16{32'h8000_0000}};
`endif
        i_acc_len = 8'd2; i_num_beats = 16'd1; i_strategy_2_en = 1'b1;
        step(1, 0, 1);
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ws_ovf_clear: got %b, required 0", o_overflow); end
        i_result_s2 = {16{32'h7FFF_FFFF}};
        step(0, 1, 1);
        i_result_s2 = {16{32'h0000_0001}};
        step(0, 1, 1);
        n_vec++; if (o_valid !== 1'b1 || o_data !== exp_beat) begin
            n_err++; $display("FAIL wrap_sat: valid=%b data=%h, required 1 %h", o_valid, o_data, exp_beat);
        end
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            step(0, 0, 1);
            if (o_done === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL ws_done: o_done=0 for 8 cycles, required 1"); end
        $display("test_wrap_sat done");
    endtask

    task automatic test_push_pop();
        logic [511:0] sent [$];
        bit got;
        i_acc_len = 8'd1; i_num_beats = 16'd4; i_strategy_2_en = 1'b1;
        step(1, 0, 0);
        for (int v = 0; v < 2; v++) begin
            rand_data(); sent.push_back(i_result_s2);
            step(0, 1, 0);
        end
        n_vec++; if (o_count !== CW'(2) || o_data !== sent[0]) begin
            n_err++; $display("FAIL pp_pre: count=%0d data=%h, required 2 %h", o_count, o_data, sent[0]);
        end
        for (int v = 2; v < 4; v++) begin
            rand_data(); sent.push_back(i_result_s2);
            step(0, 1, 1);
            n_vec++; if (o_count !== CW'(2) || o_data !== sent[v-1]) begin
                n_err++; $display("FAIL pp_simul: count=%0d data=%h, required 2 %h", o_count, o_data, sent[v-1]);
            end
        end
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            step(0, 0, 1);
            if (o_done === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL pp_done: o_done=0 for 8 cycles, required 1"); end
        $display("test_push_pop done");
    endtask

    task automatic test_zero_beats();
        int at;
        i_acc_len = 8'd1; i_num_beats = 16'd0;
        at = 0;
        step(1, 0, 0);
        if (o_done === 1'b1) at = 1;
        else begin
            step(0, 0, 0);
            if (o_done === 1'b1) at = 2;
        end
        n_vec++; if (at == 0) begin n_err++; $display("FAIL zero_done: o_done=0 within 2 cycles, required 1"); end
        n_vec++; if (o_valid !== 1'b0 || o_count !== '0) begin
            n_err++; $display("FAIL zero_nobeat: valid=%b count=%0d, required 0 0", o_valid, o_count);
        end
        step(0, 0, 0);
        if (at == 1) step(0, 0, 0);
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL zero_pulse: got %b, required 0", o_done); end
        $display("test_zero_beats done (o_done after %0d cycles)", at);
    endtask

    task automatic test_reset_mid_job();
        logic [511:0] exp_beat;
        bit got;
        i_acc_len = 8'd1; i_num_beats = 16'd8; i_strategy_2_en = 1'b1;
        step(1, 0, 0);
        for (int v = 0; v < 3; v++) begin rand_data(); step(0, 1, 0); end
        n_vec++; if (o_count !== CW'(3)) begin n_err++; $display("FAIL rmj_pre: count=%0d, required 3", o_count); end
        #2 i_rst_n = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0 || o_count !== '0) begin
            n_err++; $display("FAIL rmj_clear: valid=%b count=%0d, required 0 0", o_valid, o_count);
        end
        n_vec++; if (o_busy !== 1'b1 || o_done !== 1'b0 || o_overflow !== 1'b0) begin
            n_err++; $display("FAIL rmj_idle: busy=%b done=%b ovf=%b, required 1 0 0", o_busy, o_done, o_overflow);
        end
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_num_beats = 16'd1;
        step(1, 0, 0);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rmj_restart: busy=%b, required 0", o_busy); end
        rand_data();
        exp_beat = i_result_s2;
        step(0, 1, 0);
        n_vec++; if (o_count !== CW'(1) || o_data !== exp_beat) begin
            n_err++; $display("FAIL rmj_beat: count=%0d data=%h, required 1 %h", o_count, o_data, exp_beat);
        end
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            step(0, 0, 1);
            if (o_done === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL rmj_done: o_done=0 for 8 cycles, required 1"); end
        $display("test_reset_mid_job done");
    endtask

    task automatic test_random();
        bit busy_exp;
        int budget;
        for (int job = 0; job < 8; job++) begin
            i_acc_len   = 8'($urandom_range(0, 4));
            i_num_beats = 16'($urandom_range(1, 5));
            $display("random job %0d: acc_len=%0d num_beats=%0d", job, i_acc_len, i_num_beats);
            step(1, 0, 1'($urandom_range(0, 1)));
            budget = 0;
            while (!m_done && budget < 400) begin
                rand_data();
                i_strategy_2_en = 1'($urandom_range(0, 1));
                step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
                busy_exp = (m_phase != 1) || (m_fifo.size() == DEPTH);
                n_vec++; if (o_valid !== (m_fifo.size() != 0)) begin
                    n_err++; $display("FAIL rnd_valid: got %b, required %b", o_valid, m_fifo.size() != 0);
                end
                n_vec++; if (o_count !== CW'(m_fifo.size())) begin
                    n_err++; $display("FAIL rnd_count: got %0d, required %0d", o_count, m_fifo.size());
                end
                n_vec++; if (o_busy !== busy_exp) begin
                    n_err++; $display("FAIL rnd_busy: got %b, required %b", o_busy, busy_exp);
                end
                n_vec++; if (o_overflow !== m_ovf) begin
                    n_err++; $display("FAIL rnd_overflow: got %b, required %b", o_overflow, m_ovf);
                end
                n_vec++; if (o_done !== m_done) begin
                    n_err++; $display("FAIL rnd_done: got %b, required %b", o_done, m_done);
                end
                if (m_fifo.size() != 0) begin
                    n_vec++; if (o_data !== m_fifo[0]) begin
                        n_err++; $display("FAIL rnd_data: got %h, required %h", o_data, m_fifo[0]);
                    end
                end
                budget++;
            end
            n_vec++; if (!m_done) begin n_err++; $display("FAIL rnd_timeout: job %0d did not finish in 400 cycles", job); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_sign_ext();
        test_accumulate();
        test_back_pressure();
        test_wrap_sat();
        test_push_pop();
        test_zero_beats();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
